// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit with HI/LO result registers.
// Multiply is radix-2 shift-add; divide is restoring shift-subtract. Both run
// on operand magnitudes. The signs are applied in FIX, which takes two edges:
// the first corrects the working registers and the second commits them to HI/LO.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_dbz;
    logic               r_fix_phase;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     r_p_hi;
    logic [WIDTH-1:0]   r_p_lo;

    // Operand magnitudes and result signs, evaluated at the accept edge.
    // op[0] = 0 selects the signed forms (MULT/DIV); op[1] selects divide.
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_dbz;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_dbz    = op[1] & (b == '0);
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // One iteration of each datapath. A multiply accumulates into r_p_hi and
    // shifts the product right through r_p_lo, which starts out holding the
    // multiplier. A divide shifts the dividend out of r_p_lo into the partial
    // remainder and shifts quotient bits in behind it.
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_mul_hi;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;

    assign w_add    = r_p_hi + {1'b0, r_mcand};
    assign w_mul_hi = r_p_lo[0] ? w_add : r_p_hi;
    assign w_shift  = {r_p_hi[WIDTH-1:0], r_p_lo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_mcand};

    // Sign correction applied in the first FIX cycle.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    assign w_prod     = {r_p_hi[WIDTH-1:0], r_p_lo};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    assign w_q_fix    = r_neg_lo ? -r_p_lo : r_p_lo;
    assign w_r_fix    = r_neg_hi ? -r_p_hi[WIDTH-1:0] : r_p_hi[WIDTH-1:0];

    assign o_dbg_state = r_state;

    // Control FSM and datapath: accept, iterate WIDTH times, correct, commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_is_div    <= 1'b0;
            r_neg_lo    <= 1'b0;
            r_neg_hi    <= 1'b0;
            r_dbz       <= 1'b0;
            r_fix_phase <= 1'b0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_p_hi      <= '0;
            r_p_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // A start in the same cycle as a write strobe drops the write.
                        r_is_div    <= op[1];
                        r_neg_lo    <= (w_a_neg ^ w_b_neg) & ~w_dbz;
                        r_neg_hi    <= op[1] & w_a_neg;
                        r_dbz       <= w_dbz;
                        r_mcand     <= w_b_mag;
                        r_p_hi      <= '0;
                        r_p_lo      <= op[1] ? w_a_mag : w_b_mag;
                        r_cnt       <= '0;
                        r_fix_phase <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= S_CALC;
                        // A multiply adds |a| for each set bit of |b|, so the
                        // addend register holds |a| and r_p_lo holds |b|.
                        if (!op[1]) begin
                            r_mcand <= w_a_mag;
                        end
                    end else begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        if (!w_diff[WIDTH]) begin
                            r_p_hi <= w_diff;
                            r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_p_hi <= w_shift;
                            r_p_lo <= {r_p_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_p_hi <= {1'b0, w_mul_hi[WIDTH:1]};
                        r_p_lo <= {w_mul_hi[0], r_p_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!r_fix_phase) begin
                        if (r_is_div) begin
                            r_p_lo <= w_q_fix;
                            r_p_hi <= {1'b0, w_r_fix};
                        end else begin
                            {r_p_hi, r_p_lo} <= {1'b0, w_prod_fix};
                        end
                        r_fix_phase <= 1'b1;
                    end else begin
                        hi          <= r_p_hi[WIDTH-1:0];
                        lo          <= r_p_lo;
                        done        <= 1'b1;
                        div_by_zero <= r_dbz;
                        busy        <= 1'b0;
                        r_fix_phase <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed vectors for multiply, divide,
// divide-by-zero, signed overflow, HI/LO writes, ignored starts, back-to-back
// operations and reset in the middle of an operation.
module tb_md_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    md_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one start pulse (optionally with hi_we) across a single rising
    // edge and returns #1 after that accept edge. Operands are scrambled
    // afterwards so any late sampling shows up in the result.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic hw, input logic [W-1:0] wd);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1; hi_we = hw; wdata = wd;
        @(posedge clk);
        #1;
        start = 1'b0; hi_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    // Waits (bounded) for done; reports edges waited, cycles busy was seen
    // high, and cycles div_by_zero was seen high before done.
    task automatic wait_done(output int lat, output int bc, output int early);
        lat = 0; bc = 0; early = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) bc++;
            if (div_by_zero === 1'b1) early++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz);
        int lat, bc, early;
        launch(o, x, y, 1'b0, '0);
        wait_done(lat, bc, early);
        chk({tag, "_latency"}, W'(lat), W'(LAT));
        chk({tag, "_busy_cycles"}, W'(bc), W'(LAT));
        chk({tag, "_dbz_early"}, W'(early), '0);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_dbz"}, W'(div_by_zero), W'(edbz));
        chk({tag, "_busy_at_done"}, W'(busy), '0);
    endtask

    initial begin
        int lat, bc, early, seen;

        // Reset state
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_dbz", W'(div_by_zero), '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        @(negedge clk);
        reset = 1'b1;

        // MULTU max*max, then done is a single pulse
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        chk("multu_done_pulse", W'(done), '0);

        // Signed multiply / divide
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_negb", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("mult_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd3, 32'h0000_0000, 32'h5555_5555, 1'b0);

        // Divide by zero, then the flag drops with done
        run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        chk("divu_zero_flag_pulse", W'(div_by_zero), '0);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // Signed overflow
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

        // Idle HI/LO writes
        @(negedge clk); hi_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk); #1; hi_we = 1'b0;
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo_kept", lo, 32'h8000_0000);
        @(negedge clk); lo_we = 1'b1; wdata = 32'h0000_5678;
        @(posedge clk); #1; lo_we = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_5678);
        chk("mtlo_hi_kept", hi, 32'h0000_1234);
        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
        chk("mt_both_hi", hi, 32'h0000_ABCD);
        chk("mt_both_lo", lo, 32'h0000_ABCD);

        // start and lo_we while busy are ignored
        launch(2'b01, 32'd3, 32'd5, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd0; lo_we = 1'b1; wdata = 32'h0000_DEAD;
            @(posedge clk); #1;
            start = 1'b0; lo_we = 1'b0;
        end
        chk("busy_write_lo_kept", lo, 32'h0000_ABCD);
        chk("busy_still_busy", W'(busy), 32'd1);
        wait_done(lat, bc, early);
        chk("busy_ign_latency", W'(lat + 5), W'(LAT));
        chk("busy_ign_lo", lo, 32'd15);
        chk("busy_ign_hi", hi, 32'd0);
        chk("busy_ign_dbz", W'(div_by_zero), '0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_ign_no_queue", W'(busy), '0);

        // start and hi_we together: start wins
        @(negedge clk); hi_we = 1'b1; wdata = 32'h0000_1111;
        @(posedge clk); #1; hi_we = 1'b0;
        launch(2'b01, 32'd2, 32'd3, 1'b1, 32'h0000_BEEF);
        chk("start_hiwe_hi_held", hi, 32'h0000_1111);
        wait_done(lat, bc, early);
        chk("start_hiwe_latency", W'(lat), W'(LAT));
        chk("start_hiwe_hi", hi, 32'd0);
        chk("start_hiwe_lo", lo, 32'd6);

        // Back-to-back: the second start lands in the done cycle
        run_op("b2b_first", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
        run_op("b2b_second", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Reset mid-operation
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0);
        repeat (9) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", W'(busy), '0);
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        chk("midrst_done", W'(done), '0);
        @(negedge clk); reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("midrst_no_done", W'(seen), '0);
        run_op("post_rst_multu", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
